// File: rtl/ysyx_22041752_lsu_pkg.sv
// rtl/ysyx_22041752_lsu_pkg.sv - shared size codes, FSM states and lane helper for the LSU
package ysyx_22041752_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Byte lanes touched by an access of the given size, before shifting to the offset.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_22041752_lsu_fmt.sv
// rtl/ysyx_22041752_lsu_fmt.sv - combinational store lane shift, load extract/extend, misalign check
module ysyx_22041752_lsu_fmt
    import ysyx_22041752_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [7:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_misalign
);

    logic [2:0]      w_off;
    logic [5:0]      w_sh;
    logic [XLEN-1:0] w_t;

    assign w_off   = i_addr[2:0];
    assign w_sh    = {w_off, 3'b000};
    assign o_wstrb = lane_mask(i_size) << w_off;
    assign o_wdata = i_wdata << w_sh;
    assign w_t     = i_rdata >> w_sh;

    always_comb begin
        o_rdata = w_t;
        case (i_size)
            SZ_B: o_rdata = i_unsigned ? {{(XLEN-8){1'b0}}, w_t[7:0]}
                                       : {{(XLEN-8){w_t[7]}}, w_t[7:0]};
            SZ_H: o_rdata = i_unsigned ? {{(XLEN-16){1'b0}}, w_t[15:0]}
                                       : {{(XLEN-16){w_t[15]}}, w_t[15:0]};
            SZ_W: o_rdata = i_unsigned ? {{(XLEN-32){1'b0}}, w_t[31:0]}
                                       : {{(XLEN-32){w_t[31]}}, w_t[31:0]};
            default: o_rdata = w_t;
        endcase
    end

    always_comb begin
        o_misalign = 1'b0;
        case (i_size)
            SZ_H:    o_misalign = i_addr[0];
            SZ_W:    o_misalign = |i_addr[1:0];
            SZ_D:    o_misalign = |i_addr[2:0];
            default: o_misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041752_lsu.sv
// rtl/ysyx_22041752_lsu.sv - single-outstanding load/store unit between execute and writeback
module ysyx_22041752_lsu
    import ysyx_22041752_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_wen,
    output logic [XLEN-1:0] req_addr,
    output logic [7:0]      req_wstrb,
    output logic [XLEN-1:0] req_wdata,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_wen,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misalign
);

    lsu_state_t      r_state;
    lsu_state_t      w_next;
    logic            r_store;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic            r_misalign;
    logic [XLEN-1:0] r_rdata;

    logic            w_idle;
    logic [1:0]      w_size;
    logic [XLEN-1:0] w_addr;
    logic [7:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ldata;
    logic            w_misalign;

    // In IDLE the formatter looks at the incoming op so misalignment is known at accept.
    assign w_idle = (r_state == ST_IDLE);
    assign w_size = w_idle ? in_size : r_size;
    assign w_addr = w_idle ? in_addr : r_addr;

    ysyx_22041752_lsu_fmt #(.XLEN(XLEN)) u_fmt (
        .i_size     (w_size),
        .i_unsigned (r_unsigned),
        .i_addr     (w_addr),
        .i_wdata    (r_wdata),
        .i_rdata    (r_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ldata),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_store    <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_misalign <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle && in_valid) begin
                r_store    <= in_store;
                r_size     <= in_size;
                r_unsigned <= in_unsigned;
                r_addr     <= in_addr;
                r_wdata    <= in_wdata;
                r_rd       <= in_rd;
                r_misalign <= w_misalign;
            end
            if (r_state == ST_RESP && resp_valid) begin
                r_rdata <= resp_rdata;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_addr    = '0;
        req_wstrb   = 8'h00;
        req_wdata   = '0;
        wb_valid    = 1'b0;
        wb_wen      = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = '0;
        wb_misalign = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = w_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                req_wen   = r_store;
                req_addr  = {r_addr[XLEN-1:3], 3'b000};
                req_wstrb = r_store ? w_wstrb : 8'h00;
                req_wdata = r_store ? w_wdata : '0;
                if (req_ready) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_valid) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_valid    = 1'b1;
                wb_wen      = !r_store && !r_misalign;
                wb_rd       = r_rd;
                wb_data     = (!r_store && !r_misalign) ? w_ldata : '0;
                wb_misalign = r_misalign;
                if (wb_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
